// File: rtl/speed_key_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : speed_key_sequencer
//  Brief    : Synchronizes and debounces three active-low push-buttons and
//             turns them into single-cycle speed commands with auto-repeat
//             on the up/down keys and a non-repeating speed-reset command.
//  Revision : 1.0 - initial release
// ============================================================================
module speed_key_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] i_key_n,
  output logic       o_step_up,
  output logic       o_step_down,
  output logic       o_speed_reset,
  output logic [2:0] o_key_held
);

  localparam logic [31:0] c_DB_LAST  = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] c_DLY_LAST = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] c_PER_LAST = 32'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2,
    S_LOCK   = 2'd3
  } state_t;

  logic [2:0]  r_sync1;
  logic [2:0]  r_sync2;
  logic [2:0]  r_key_held;   // debounced pressed state, 1 = pressed
  logic [2:0]  r_held_d;
  logic [31:0] r_db_cnt [3];

  state_t      r_state;
  logic        r_dir;        // latched direction: 0 = up, 1 = down
  logic [31:0] r_rpt_cnt;
  logic        r_step_up;
  logic        r_step_down;
  logic        r_speed_reset;

  state_t      w_state_nxt;
  logic        w_dir_nxt;
  logic [31:0] w_cnt_nxt;
  logic        w_up_nxt;
  logic        w_down_nxt;
  logic        w_rst_nxt;
  logic [2:0]  w_press;
  logic        w_both_held;
  logic        w_lat_held;

  // Two-flop synchronizer; idle level is released (1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 3'b111;
      r_sync2 <= 3'b111;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: the held state flips only after DEBOUNCE_CYCLES of disagreement.
  // The synchronized key is active-low, so equality with the held bit means
  // the two disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_held <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_key_held[i]) begin
          if (r_db_cnt[i] == c_DB_LAST) begin
            r_key_held[i] <= ~r_sync2[i];
            r_db_cnt[i]   <= '0;
          end else begin
            r_db_cnt[i]   <= r_db_cnt[i] + 32'd1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  // Delayed copy of the held state for press (rising edge) detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held_d <= 3'b000;
    end else begin
      r_held_d <= r_key_held;
    end
  end

  assign w_press     = r_key_held & ~r_held_d;
  assign w_both_held = r_key_held[0] & r_key_held[1];
  assign w_lat_held  = r_dir ? r_key_held[1] : r_key_held[0];

  // State, direction, repeat counter and output pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_dir         <= 1'b0;
      r_rpt_cnt     <= '0;
      r_step_up     <= 1'b0;
      r_step_down   <= 1'b0;
      r_speed_reset <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_dir         <= w_dir_nxt;
      r_rpt_cnt     <= w_cnt_nxt;
      r_step_up     <= w_up_nxt;
      r_step_down   <= w_down_nxt;
      r_speed_reset <= w_rst_nxt;
    end
  end

  // Next-state and pulse arbitration: reset key, then lock, then up/down.
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_cnt_nxt   = r_rpt_cnt;
    w_up_nxt    = 1'b0;
    w_down_nxt  = 1'b0;
    w_rst_nxt   = w_press[2];

    if (r_key_held[2]) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_both_held) begin
            w_state_nxt = S_LOCK;
          end else if (w_press[0] || w_press[1]) begin
            w_dir_nxt   = w_press[1];
            w_up_nxt    = w_press[0];
            w_down_nxt  = w_press[1];
            w_cnt_nxt   = '0;
            w_state_nxt = S_DELAY;
          end
        end
        S_DELAY, S_REPEAT: begin
          if (w_both_held) begin
            w_state_nxt = S_LOCK;
          end else if (!w_lat_held) begin
            w_state_nxt = S_IDLE;
          end else if (r_rpt_cnt == ((r_state == S_DELAY) ? c_DLY_LAST : c_PER_LAST)) begin
            w_up_nxt    = ~r_dir;
            w_down_nxt  = r_dir;
            w_cnt_nxt   = '0;
            w_state_nxt = S_REPEAT;
          end else begin
            w_cnt_nxt   = r_rpt_cnt + 32'd1;
          end
        end
        S_LOCK: begin
          if (r_key_held[1:0] == 2'b00) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign o_step_up     = r_step_up;
  assign o_step_down   = r_step_down;
  assign o_speed_reset = r_speed_reset;
  assign o_key_held    = r_key_held;

endmodule
`default_nettype wire

// File: tb/tb_speed_key_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_speed_key_sequencer
//  Brief    : Directed, table-driven bench for speed_key_sequencer with
//             DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_speed_key_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] key_n = 3'b111;
  logic       step_up;
  logic       step_down;
  logic       speed_reset;
  logic [2:0] key_held;

  always #5 clk = ~clk;

  speed_key_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_key_n       (key_n),
    .o_step_up     (step_up),
    .o_step_down   (step_down),
    .o_speed_reset (speed_reset),
    .o_key_held    (key_held)
  );

  typedef struct {
    logic [2:0] mask;      // keys pressed (1 = pressed)
    int         len;       // cycles the keys are held low
    int         total;     // cycles observed
    int         exp_up;
    int         exp_down;
    int         exp_rst;
    int         exp_first; // cycle of first pulse, -1 if none
    int         exp_last;  // cycle of last pulse, -1 if none
    int         exp_rise;  // first cycle key_held != 0, -1 if none
    int         exp_fall;  // first cycle after rise with key_held == 0
  } vec_t;

  vec_t vecs [9];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Press the keys in mask for len cycles, observe for total cycles.
  // Cycle c is sampled 1 time unit after the c-th rising edge.
  task automatic apply(input vec_t v, input int idx);
    int up = 0, dn = 0, rs = 0, excl = 0;
    int first = -1, last = -1, rise = -1, fall = -1;
    @(posedge clk); #1;
    key_n = ~v.mask;
    for (int c = 1; c <= v.total; c++) begin
      @(posedge clk); #1;
      if (step_up)     up++;
      if (step_down)   dn++;
      if (speed_reset) rs++;
      if (step_up || step_down || speed_reset) begin
        if (first < 0) first = c;
        last = c;
      end
      if ((int'(step_up) + int'(step_down) + int'(speed_reset)) > 1) excl++;
      if (key_held != 3'b000 && rise < 0) rise = c;
      if (rise >= 0 && fall < 0 && key_held == 3'b000) fall = c;
      if (c == v.len) key_n = 3'b111;
    end
    chk($sformatf("vec%0d up_count", idx),    up,    v.exp_up);
    chk($sformatf("vec%0d down_count", idx),  dn,    v.exp_down);
    chk($sformatf("vec%0d reset_count", idx), rs,    v.exp_rst);
    chk($sformatf("vec%0d first_pulse", idx), first, v.exp_first);
    chk($sformatf("vec%0d last_pulse", idx),  last,  v.exp_last);
    chk($sformatf("vec%0d held_rise", idx),   rise,  v.exp_rise);
    chk($sformatf("vec%0d held_fall", idx),   fall,  v.exp_fall);
    chk($sformatf("vec%0d exclusive", idx),   excl,  0);
  endtask

  initial begin
    int up, dn, rs, rs_cyc, up_while, up_pre, up_mid, up_fresh, fresh_cyc, held_cnt, first;

    //                mask  len tot  up dn rs first last rise fall
    vecs[0] = '{3'b001,  8, 30,  1, 0, 0,  7,  7,  6, 14};
    vecs[1] = '{3'b010,  8, 30,  0, 1, 0,  7,  7,  6, 14};
    vecs[2] = '{3'b100,  8, 30,  0, 0, 1,  7,  7,  6, 14};
    vecs[3] = '{3'b001,  3, 25,  0, 0, 0, -1, -1, -1, -1};
    vecs[4] = '{3'b010,  4, 25,  0, 1, 0,  7,  7,  6, 10};
    vecs[5] = '{3'b011,  8, 30,  0, 0, 0, -1, -1,  6, 14};
    vecs[6] = '{3'b001, 20, 45,  5, 0, 0,  7, 26,  6, 26};
    vecs[7] = '{3'b010, 40, 65,  0, 11, 0, 7, 44,  6, 46};
    vecs[8] = '{3'b100, 40, 65,  0, 0, 1,  7,  7,  6, 46};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset step_up",     int'(step_up),     0);
    chk("reset step_down",   int'(step_down),   0);
    chk("reset speed_reset", int'(speed_reset), 0);
    chk("reset key_held",    int'(key_held),    0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Table-driven vectors
    for (int i = 0; i < 9; i++) begin
      apply(vecs[i], i);
    end

    // Bounce: key 1 toggles every 2 cycles for 20 cycles
    rs = 0; held_cnt = 0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      if (step_up || step_down || speed_reset) rs++;
      if (key_held != 3'b000) held_cnt++;
      key_n = (c < 20 && ((c / 2) % 2 == 0)) ? 3'b101 : 3'b111;
    end
    chk("bounce pulses", rs, 0);
    chk("bounce held_cycles", held_cnt, 0);

    // Reset-key priority while key 0 is in auto-repeat
    up = 0; rs = 0; rs_cyc = -1; up_while = 0;
    @(posedge clk); #1;
    key_n = 3'b110;
    for (int c = 1; c <= 65; c++) begin
      @(posedge clk); #1;
      if (step_up) begin
        up++;
        if (key_held[2]) up_while++;
      end
      if (speed_reset) begin
        rs++;
        rs_cyc = c;
      end
      if (c == 21) key_n[2] = 1'b0;
      if (c == 51) key_n = 3'b111;
    end
    chk("rstkey up_count", up, 5);
    chk("rstkey up_while_held", up_while, 0);
    chk("rstkey reset_count", rs, 1);
    chk("rstkey reset_cycle", rs_cyc, 28);

    // Lock: key 1 joins key 0, released separately, then key 0 re-pressed
    up_pre = 0; up_mid = 0; up_fresh = 0; fresh_cyc = -1; dn = 0;
    @(posedge clk); #1;
    key_n = 3'b110;
    for (int c = 1; c <= 115; c++) begin
      @(posedge clk); #1;
      if (step_up) begin
        if (c < 24)      up_pre++;
        else if (c < 91) up_mid++;
        else begin
          up_fresh++;
          if (fresh_cyc < 0) fresh_cyc = c;
        end
      end
      if (step_down) dn++;
      if (c == 60) chk("lock held_after_key1_release", int'(key_held), 1);
      if (c == 18)  key_n[1] = 1'b0;
      if (c == 40)  key_n[1] = 1'b1;
      if (c == 70)  key_n[0] = 1'b1;
      if (c == 90)  key_n[0] = 1'b0;
      if (c == 100) key_n[0] = 1'b1;
    end
    chk("lock up_before_lock", up_pre, 4);
    chk("lock up_during_lock", up_mid, 0);
    chk("lock down_count", dn, 0);
    chk("lock fresh_up_count", up_fresh, 1);
    chk("lock fresh_up_cycle", fresh_cyc, 97);

    // Asynchronous reset in the middle of auto-repeat
    @(posedge clk); #1;
    key_n = 3'b110;
    for (int c = 1; c <= 23; c++) begin
      @(posedge clk); #1;
    end
    chk("areset pulse_before", int'(step_up), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset step_up", int'(step_up), 0);
    chk("areset key_held", int'(key_held), 0);
    chk("areset other_pulses", int'(step_down) + int'(speed_reset), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    up = 0; first = -1;
    for (int c = 25; c <= 40; c++) begin
      @(posedge clk); #1;
      if (step_up) begin
        up++;
        if (first < 0) first = c;
      end
    end
    chk("areset first_up_cycle", first, 31);
    chk("areset up_count", up, 1);
    key_n = 3'b111;
    repeat (20) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
